// File: rtl/exe_branch_unit_if.sv
// Bundles the EXE-stage branch unit command inputs and redirect/status outputs.
// slave is the branch unit side; master is the side driving the EXE slot.
interface exe_branch_unit_if #(
  parameter int ADDR_W    = 16,
  parameter int FLAG_W    = 3,
  parameter int INT_DEPTH = 4
);
  localparam int LVL_W = $clog2(INT_DEPTH + 1);

  logic              valid;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] target;
  logic              br;
  logic [FLAG_W-1:0] cond;
  logic              call;
  logic              ret;
  logic              reti;
  logic              flag_wr;
  logic [FLAG_W-1:0] flags_in;
  logic              int_req;
  logic [ADDR_W-1:0] int_vector;

  logic              int_ack;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_addr;
  logic [FLAG_W-1:0] flags;
  logic [LVL_W-1:0]  int_level;
  logic              in_isr;
  logic              ras_ovf;
  logic              ras_unf;
  logic              reti_err;

  modport master (
    output valid, pc, target, br, cond, call, ret, reti, flag_wr, flags_in,
           int_req, int_vector,
    input  int_ack, branch_taken, branch_addr, flags, int_level, in_isr,
           ras_ovf, ras_unf, reti_err
  );

  modport slave (
    input  valid, pc, target, br, cond, call, ret, reti, flag_wr, flags_in,
           int_req, int_vector,
    output int_ack, branch_taken, branch_addr, flags, int_level, in_isr,
           ras_ovf, ras_unf, reti_err
  );
endinterface

// File: rtl/exe_branch_unit.sv
// EXE-stage branch unit: flag register, circular return-address stack and nested
// interrupt-context stack. Optional macro BRU_CTX_FLAGS_EN saves/restores flags with context.
module exe_branch_unit #(
  parameter int ADDR_W    = 16,
  parameter int RAS_DEPTH = 8,
  parameter int INT_DEPTH = 4,
  parameter int FLAG_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  exe_branch_unit_if.slave  bus
);
  localparam int PTR_W  = $clog2(RAS_DEPTH);
  localparam int CNT_W  = $clog2(RAS_DEPTH + 1);
  localparam int LVL_W  = $clog2(INT_DEPTH + 1);
  localparam int CTX_IW = (INT_DEPTH > 1) ? $clog2(INT_DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);
  localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(INT_DEPTH);

  logic [ADDR_W-1:0] r_ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  r_ras_ptr;
  logic [CNT_W-1:0]  r_ras_cnt;
  logic [ADDR_W-1:0] r_ctx_pc [INT_DEPTH];
`ifdef BRU_CTX_FLAGS_EN
  logic [FLAG_W-1:0] r_ctx_flags [INT_DEPTH];
`endif
  logic [FLAG_W-1:0] r_flags;
  logic [LVL_W-1:0]  r_int_level;
  logic              r_ras_ovf;
  logic              r_ras_unf;
  logic              r_reti_err;

  logic [PTR_W-1:0]  w_ptr_inc;
  logic [PTR_W-1:0]  w_ptr_dec;
  logic [ADDR_W-1:0] w_ras_top;
  logic              w_ras_empty;
  logic              w_ras_full;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [LVL_W-1:0]  w_lvl_dec;
  logic              w_accept;
  logic              w_taken;
  logic [ADDR_W-1:0] w_addr;
  logic              w_push;
  logic              w_pop;
  logic              w_replace;
  logic              w_unf;
  logic              w_ctx_push;
  logic              w_ctx_pop;
  logic              w_reti_bad;
  logic              w_flag_load;

  // r_ras_ptr is the next write slot; the top entry sits one below it (circular).
  assign w_ptr_inc   = (r_ras_ptr == PTR_LAST) ? '0 : r_ras_ptr + PTR_W'(1);
  assign w_ptr_dec   = (r_ras_ptr == '0) ? PTR_LAST : r_ras_ptr - PTR_W'(1);
  assign w_ras_top   = r_ras_mem[w_ptr_dec];
  assign w_ras_empty = (r_ras_cnt == '0);
  assign w_ras_full  = (r_ras_cnt == CNT_FULL);
  assign w_pc_inc    = bus.pc + ADDR_W'(1);
  assign w_lvl_dec   = r_int_level - LVL_W'(1);
  assign w_accept    = bus.valid & bus.int_req & ~bus.reti & (r_int_level < LVL_MAX);

  always_comb begin
    w_taken     = 1'b0;
    w_addr      = '0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_replace   = 1'b0;
    w_unf       = 1'b0;
    w_ctx_push  = 1'b0;
    w_ctx_pop   = 1'b0;
    w_reti_bad  = 1'b0;
    w_flag_load = 1'b0;
    if (w_accept) begin
      w_taken    = 1'b1;
      w_addr     = bus.int_vector;
      w_ctx_push = 1'b1;
    end else if (bus.valid) begin
      w_flag_load = bus.flag_wr;
      if (bus.reti) begin
        if (r_int_level != '0) begin
          w_taken   = 1'b1;
          w_addr    = r_ctx_pc[w_lvl_dec[CTX_IW-1:0]];
          w_ctx_pop = 1'b1;
        end else begin
          w_reti_bad  = 1'b1;
          w_flag_load = 1'b0;
        end
      end else if (bus.ret) begin
        w_taken = 1'b1;
        w_addr  = w_ras_empty ? '0 : w_ras_top;
        if (w_ras_empty) begin
          w_unf  = 1'b1;
          w_push = bus.call;
        end else if (bus.call) begin
          w_replace = 1'b1;
        end else begin
          w_pop = 1'b1;
        end
      end else if (bus.call) begin
        w_taken = 1'b1;
        w_addr  = bus.target;
        w_push  = 1'b1;
      end else if (bus.br) begin
        w_taken = |(bus.cond & r_flags);
        w_addr  = bus.target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags     <= '0;
      r_ras_ptr   <= '0;
      r_ras_cnt   <= '0;
      r_int_level <= '0;
      r_ras_ovf   <= 1'b0;
      r_ras_unf   <= 1'b0;
      r_reti_err  <= 1'b0;
    end else begin
      if (w_push) begin
        r_ras_ptr <= w_ptr_inc;
        if (w_ras_full) r_ras_ovf <= 1'b1;
        else            r_ras_cnt <= r_ras_cnt + CNT_W'(1);
      end else if (w_pop) begin
        r_ras_ptr <= w_ptr_dec;
        r_ras_cnt <= r_ras_cnt - CNT_W'(1);
      end
      if (w_unf)      r_ras_unf  <= 1'b1;
      if (w_reti_bad) r_reti_err <= 1'b1;
      if (w_ctx_push)     r_int_level <= r_int_level + LVL_W'(1);
      else if (w_ctx_pop) r_int_level <= w_lvl_dec;
`ifdef BRU_CTX_FLAGS_EN
      if (w_ctx_pop)        r_flags <= r_ctx_flags[w_lvl_dec[CTX_IW-1:0]];
      else if (w_flag_load) r_flags <= bus.flags_in;
`else
      if (w_flag_load) r_flags <= bus.flags_in;
`endif
    end
  end

  // Stack storage carries no reset; only the pointers/counts define validity.
  always_ff @(posedge clk) begin
    if (w_push)         r_ras_mem[r_ras_ptr] <= w_pc_inc;
    else if (w_replace) r_ras_mem[w_ptr_dec] <= w_pc_inc;
    if (w_ctx_push) begin
      r_ctx_pc[r_int_level[CTX_IW-1:0]] <= bus.pc;
`ifdef BRU_CTX_FLAGS_EN
      r_ctx_flags[r_int_level[CTX_IW-1:0]] <= r_flags;
`endif
    end
  end

  assign bus.int_ack      = w_accept;
  assign bus.branch_taken = w_taken;
  assign bus.branch_addr  = w_addr;
  assign bus.flags        = r_flags;
  assign bus.int_level    = r_int_level;
  assign bus.in_isr       = (r_int_level != '0);
  assign bus.ras_ovf      = r_ras_ovf;
  assign bus.ras_unf      = r_ras_unf;
  assign bus.reti_err     = r_reti_err;
endmodule

// File: tb/tb_exe_branch_unit.sv
// Directed vector table plus randomized run against a queue-based reference model.
module tb_exe_branch_unit;
  localparam int AW = 16;
  localparam int RD = 8;
  localparam int ID = 4;
  localparam int FW = 3;

  localparam logic [6:0] C_V   = 7'h40;
  localparam logic [6:0] C_IRQ = 7'h20;
  localparam logic [6:0] C_RTI = 7'h10;
  localparam logic [6:0] C_RET = 7'h08;
  localparam logic [6:0] C_CAL = 7'h04;
  localparam logic [6:0] C_BR  = 7'h02;
  localparam logic [6:0] C_FW  = 7'h01;

`ifdef BRU_CTX_FLAGS_EN
  localparam logic [2:0] F_AFTER = 3'b010;
`else
  localparam logic [2:0] F_AFTER = 3'b100;
`endif

  typedef struct {
    logic        valid, int_req, reti, ret, call, br, flag_wr;
    logic [15:0] pc, target, vec;
    logic [2:0]  cond, flags_in;
  } in_t;

  typedef struct {
    in_t         in;
    logic        taken;
    logic [15:0] addr;
    logic        ack;
    logic [2:0]  flags;
    logic [2:0]  lvl;
    logic [2:0]  sticky;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exe_branch_unit_if #(.ADDR_W(AW), .FLAG_W(FW), .INT_DEPTH(ID)) bus ();
  exe_branch_unit #(.ADDR_W(AW), .RAS_DEPTH(RD), .INT_DEPTH(ID), .FLAG_W(FW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int   n_checks;
  int   n_fail;
  vec_t tbl[$];

  logic [15:0] m_ras[$];
  logic [15:0] m_ctx_pc[$];
  logic [2:0]  m_ctx_fl[$];
  logic [2:0]  m_flags;
  logic        m_ovf, m_unf, m_err;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input in_t x);
    bus.valid      = x.valid;
    bus.int_req    = x.int_req;
    bus.reti       = x.reti;
    bus.ret        = x.ret;
    bus.call       = x.call;
    bus.br         = x.br;
    bus.flag_wr    = x.flag_wr;
    bus.pc         = x.pc;
    bus.target     = x.target;
    bus.int_vector = x.vec;
    bus.cond       = x.cond;
    bus.flags_in   = x.flags_in;
  endtask

  function automatic in_t mk(input logic [6:0] c, input logic [15:0] pc, input logic [15:0] tgt,
                             input logic [2:0] cond, input logic [2:0] fin, input logic [15:0] vec);
    in_t x;
    {x.valid, x.int_req, x.reti, x.ret, x.call, x.br, x.flag_wr} = c;
    x.pc = pc; x.target = tgt; x.cond = cond; x.flags_in = fin; x.vec = vec;
    return x;
  endfunction

  task automatic add(input logic [6:0] c, input logic [15:0] pc, input logic [15:0] tgt,
                     input logic [2:0] cond, input logic [2:0] fin, input logic [15:0] vec,
                     input logic tk, input logic [15:0] addr, input logic ack,
                     input logic [2:0] fl, input logic [2:0] lvl, input logic [2:0] st);
    vec_t v;
    v.in = mk(c, pc, tgt, cond, fin, vec);
    v.taken = tk; v.addr = addr; v.ack = ack; v.flags = fl; v.lvl = lvl; v.sticky = st;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    drive(mk(7'h00, 16'h0, 16'h0, 3'b0, 3'b0, 16'h0));
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
  endtask

  task automatic ras_push(input logic [15:0] a);
    if (m_ras.size() == RD) begin
      void'(m_ras.pop_front());
      m_ovf = 1'b1;
    end
    m_ras.push_back(a);
  endtask

  // Reference model: computes this cycle's redirect and advances the stacks.
  task automatic model_step(input in_t x, output logic e_taken, output logic [15:0] e_addr,
                            output logic e_ack);
    logic [2:0] nf;
    logic [2:0] sfl;
    e_taken = 1'b0; e_addr = 16'h0; e_ack = 1'b0;
    nf = m_flags;
    if (x.valid && x.int_req && !x.reti && m_ctx_pc.size() < ID) begin
      e_ack = 1'b1; e_taken = 1'b1; e_addr = x.vec;
      m_ctx_pc.push_back(x.pc);
      m_ctx_fl.push_back(m_flags);
    end else if (x.valid) begin
      if (x.flag_wr) nf = x.flags_in;
      if (x.reti) begin
        if (m_ctx_pc.size() == 0) begin
          m_err = 1'b1;
          nf = m_flags;
        end else begin
          e_taken = 1'b1;
          e_addr = m_ctx_pc.pop_back();
          sfl = m_ctx_fl.pop_back();
`ifdef BRU_CTX_FLAGS_EN
          nf = sfl;
`endif
        end
      end else if (x.ret) begin
        e_taken = 1'b1;
        if (m_ras.size() == 0) begin
          m_unf = 1'b1;
          e_addr = 16'h0;
        end else begin
          e_addr = m_ras.pop_back();
        end
        if (x.call) ras_push(x.pc + 16'd1);
      end else if (x.call) begin
        e_taken = 1'b1; e_addr = x.target;
        ras_push(x.pc + 16'd1);
      end else if (x.br) begin
        e_taken = |(x.cond & m_flags);
        e_addr = x.target;
      end
    end
    m_flags = nf;
  endtask

  initial begin
    logic        e_taken, e_ack;
    logic [15:0] e_addr;
    in_t         x;
    n_checks = 0;
    n_fail   = 0;

    do_reset();
    check("reset taken", 32'(bus.branch_taken), 32'd0);
    check("reset ack", 32'(bus.int_ack), 32'd0);
    check("reset flags", 32'(bus.flags), 32'd0);
    check("reset level", 32'(bus.int_level), 32'd0);
    check("reset in_isr", 32'(bus.in_isr), 32'd0);
    check("reset sticky", 32'({bus.ras_ovf, bus.ras_unf, bus.reti_err}), 32'd0);

    // Flags and conditional branch
    add(C_V|C_FW, 16'h0001, 16'h0, 3'b000, 3'b001, 16'h0, 0, 16'h0, 0, 3'b001, 0, 3'b000);
    add(C_V|C_BR, 16'h0002, 16'h0040, 3'b001, 3'b000, 16'h0, 1, 16'h0040, 0, 3'b001, 0, 3'b000);
    add(C_V|C_BR, 16'h0003, 16'h0040, 3'b100, 3'b000, 16'h0, 0, 16'h0, 0, 3'b001, 0, 3'b000);
    add(C_CAL, 16'h0004, 16'h0077, 3'b000, 3'b000, 16'h0, 0, 16'h0, 0, 3'b001, 0, 3'b000);
    // RAS overflow then drain
    for (int i = 0; i < 9; i++)
      add(C_V|C_CAL, 16'(16'h0010 + i), 16'(16'h0200 + i), 3'b0, 3'b0, 16'h0,
          1, 16'(16'h0200 + i), 0, 3'b001, 0, (i == 8) ? 3'b100 : 3'b000);
    for (int i = 0; i < 8; i++)
      add(C_V|C_RET, 16'h0300, 16'h0, 3'b0, 3'b0, 16'h0, 1, 16'(16'h0019 - i), 0, 3'b001, 0, 3'b100);
    add(C_V|C_CAL, 16'hFFFF, 16'h0123, 3'b0, 3'b0, 16'h0, 1, 16'h0123, 0, 3'b001, 0, 3'b100);
    add(C_V|C_RET, 16'h0124, 16'h0, 3'b0, 3'b0, 16'h0, 1, 16'h0000, 0, 3'b001, 0, 3'b100);
    add(C_V|C_RET, 16'h0001, 16'h0, 3'b0, 3'b0, 16'h0, 1, 16'h0000, 0, 3'b001, 0, 3'b110);
    add(C_V|C_RET|C_CAL, 16'h0050, 16'h0999, 3'b0, 3'b0, 16'h0, 1, 16'h0000, 0, 3'b001, 0, 3'b110);
    add(C_V|C_RET|C_CAL, 16'h0060, 16'h0999, 3'b0, 3'b0, 16'h0, 1, 16'h0051, 0, 3'b001, 0, 3'b110);
    add(C_V|C_RET, 16'h0070, 16'h0, 3'b0, 3'b0, 16'h0, 1, 16'h0061, 0, 3'b001, 0, 3'b110);
    // Interrupt pre-empts a call
    add(C_V|C_IRQ|C_CAL, 16'h0100, 16'h0555, 3'b0, 3'b0, 16'h0F00, 1, 16'h0F00, 1, 3'b001, 1, 3'b110);
    add(C_V|C_RET, 16'h0F00, 16'h0, 3'b0, 3'b0, 16'h0, 1, 16'h0000, 0, 3'b001, 1, 3'b110);
    add(C_V|C_RTI, 16'h0F01, 16'h0, 3'b0, 3'b0, 16'h0, 1, 16'h0100, 0, 3'b001, 0, 3'b110);
    // Flag save/restore across an ISR
    add(C_V|C_FW, 16'h01F0, 16'h0, 3'b0, 3'b010, 16'h0, 0, 16'h0, 0, 3'b010, 0, 3'b110);
    add(C_V|C_IRQ|C_FW, 16'h0200, 16'h0, 3'b0, 3'b111, 16'h0F00, 1, 16'h0F00, 1, 3'b010, 1, 3'b110);
    add(C_V|C_FW, 16'h0F00, 16'h0, 3'b0, 3'b100, 16'h0, 0, 16'h0, 0, 3'b100, 1, 3'b110);
    add(C_V|C_RTI, 16'h0F01, 16'h0, 3'b0, 3'b0, 16'h0, 1, 16'h0200, 0, F_AFTER, 0, 3'b110);
    // Nesting to the limit
    add(C_IRQ, 16'h03FF, 16'h0, 3'b0, 3'b0, 16'h0F00, 0, 16'h0, 0, F_AFTER, 0, 3'b110);
    for (int i = 0; i < 4; i++)
      add(C_V|C_IRQ, 16'(16'h0400 + i), 16'h0, 3'b0, 3'b0, 16'(16'h0F00 + i),
          1, 16'(16'h0F00 + i), 1, F_AFTER, 3'(i + 1), 3'b110);
    add(C_V|C_IRQ, 16'h0404, 16'h0, 3'b0, 3'b0, 16'h0F04, 0, 16'h0, 0, F_AFTER, 4, 3'b110);
    add(C_V|C_IRQ|C_RTI, 16'h0F10, 16'h0, 3'b0, 3'b0, 16'h0F04, 1, 16'h0403, 0, F_AFTER, 3, 3'b110);
    add(C_V|C_IRQ, 16'h0F20, 16'h0, 3'b0, 3'b0, 16'h0F04, 1, 16'h0F04, 1, F_AFTER, 4, 3'b110);
    add(C_V|C_RTI, 16'h0F30, 16'h0, 3'b0, 3'b0, 16'h0, 1, 16'h0F20, 0, F_AFTER, 3, 3'b110);
    for (int i = 0; i < 3; i++)
      add(C_V|C_RTI, 16'h0F31, 16'h0, 3'b0, 3'b0, 16'h0, 1, 16'(16'h0402 - i), 0, F_AFTER, 3'(2 - i), 3'b110);
    add(C_V|C_RTI, 16'h0500, 16'h0, 3'b0, 3'b0, 16'h0, 0, 16'h0, 0, F_AFTER, 0, 3'b111);

    foreach (tbl[i]) begin
      drive(tbl[i].in);
      #2;
      check($sformatf("vec%0d taken", i), 32'(bus.branch_taken), 32'(tbl[i].taken));
      check($sformatf("vec%0d ack", i), 32'(bus.int_ack), 32'(tbl[i].ack));
      if (tbl[i].taken)
        check($sformatf("vec%0d addr", i), 32'(bus.branch_addr), 32'(tbl[i].addr));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d flags", i), 32'(bus.flags), 32'(tbl[i].flags));
      check($sformatf("vec%0d level", i), 32'(bus.int_level), 32'(tbl[i].lvl));
      check($sformatf("vec%0d in_isr", i), 32'(bus.in_isr), 32'(tbl[i].lvl != 0));
      check($sformatf("vec%0d sticky", i), 32'({bus.ras_ovf, bus.ras_unf, bus.reti_err}),
            32'(tbl[i].sticky));
      $display("vec %0d pc=%h taken=%b addr=%h ack=%b flags=%b lvl=%0d", i, tbl[i].in.pc,
               bus.branch_taken, tbl[i].addr, tbl[i].ack, bus.flags, bus.int_level);
    end

    do_reset();
    m_ras.delete(); m_ctx_pc.delete(); m_ctx_fl.delete();
    m_flags = 3'b000; m_ovf = 1'b0; m_unf = 1'b0; m_err = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      x.valid    = ($urandom_range(0, 9) != 0);
      x.int_req  = ($urandom_range(0, 4) == 0);
      x.reti     = ($urandom_range(0, 7) == 0);
      x.ret      = ($urandom_range(0, 3) == 0);
      x.call     = ($urandom_range(0, 3) == 0);
      x.br       = ($urandom_range(0, 2) == 0);
      x.flag_wr  = x.reti ? 1'b0 : ($urandom_range(0, 2) == 0);
      x.pc       = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom);
      x.target   = 16'($urandom);
      x.vec      = 16'($urandom);
      x.cond     = 3'($urandom);
      x.flags_in = 3'($urandom);
      drive(x);
      model_step(x, e_taken, e_addr, e_ack);
      #2;
      check($sformatf("rnd%0d taken", n), 32'(bus.branch_taken), 32'(e_taken));
      check($sformatf("rnd%0d ack", n), 32'(bus.int_ack), 32'(e_ack));
      if (e_taken)
        check($sformatf("rnd%0d addr", n), 32'(bus.branch_addr), 32'(e_addr));
      @(posedge clk);
      #1;
      check($sformatf("rnd%0d flags", n), 32'(bus.flags), 32'(m_flags));
      check($sformatf("rnd%0d level", n), 32'(bus.int_level), 32'(m_ctx_pc.size()));
      check($sformatf("rnd%0d in_isr", n), 32'(bus.in_isr), 32'(m_ctx_pc.size() != 0));
      check($sformatf("rnd%0d sticky", n), 32'({bus.ras_ovf, bus.ras_unf, bus.reti_err}),
            32'({m_ovf, m_unf, m_err}));
      $display("rnd %0d pc=%h taken=%b addr=%h ack=%b flags=%b lvl=%0d ras=%0d", n, x.pc,
               e_taken, e_addr, e_ack, bus.flags, bus.int_level, m_ras.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
